// File: rtl/formula_loader_if.sv
// Handshake bundle between the literal-token source, the formula loader and the formula consumer.
`timescale 1ns/1ps
interface formula_loader_if #(
    parameter int unsigned NUM_CLAUSES  = 5,
    parameter int unsigned NUM_LITERALS = 3,
    parameter int unsigned LIT_W        = $clog2(NUM_LITERALS + 1),
    parameter int unsigned CLS_W        = $clog2(NUM_CLAUSES),
    parameter int unsigned FM_W         = NUM_CLAUSES * (NUM_LITERALS * (LIT_W + 1) + LIT_W) + CLS_W
);
    logic             in_valid;
    logic             in_ready;
    logic [LIT_W-1:0] in_num;
    logic             in_val;
    logic             in_eoc;
    logic             in_eof;
    logic [FM_W-1:0]  fm_data;
    logic             fm_valid;
    logic             fm_ready;
    logic             err;

    modport master (
        output in_valid, in_num, in_val, in_eoc, in_eof, fm_ready,
        input  in_ready, fm_data, fm_valid, err
    );

    modport slave (
        input  in_valid, in_num, in_val, in_eoc, in_eof, fm_ready,
        output in_ready, fm_data, fm_valid, err
    );
endinterface

// File: rtl/formula_loader.sv
// Builds a packed SAT formula (clauses[0] in the MSBs, formula len in the LSBs) from a stream
// of literal tokens; malformed streams are flagged on err and dropped up to their eof token.
`timescale 1ns/1ps
module formula_loader #(
    parameter int unsigned NUM_CLAUSES  = 5,
    parameter int unsigned NUM_LITERALS = 3,
    parameter int unsigned LIT_W        = $clog2(NUM_LITERALS + 1),
    parameter int unsigned CLS_W        = $clog2(NUM_CLAUSES)
) (
    input  logic             clk,
    input  logic             rst_n,
    formula_loader_if.slave  bus
);
    localparam int unsigned LIT_BITS = LIT_W + 1;
    localparam int unsigned CLAUSE_W = NUM_LITERALS * LIT_BITS + LIT_W;
    localparam int unsigned FM_W     = NUM_CLAUSES * CLAUSE_W + CLS_W;

    typedef enum logic [1:0] {StCollect, StDone, StErr} state_e;

    state_e              state_q;
    logic [LIT_BITS-1:0] lits_q [NUM_CLAUSES][NUM_LITERALS];
    logic [LIT_W-1:0]    clen_q [NUM_CLAUSES];
    logic [CLS_W-1:0]    flen_q;
    logic [LIT_W-1:0]    lidx_q;
    logic [CLS_W-1:0]    cidx_q;
    logic                fm_valid_q;
    logic                err_q;
    logic                err_once_q;

    logic accept, bad, end_cls, wr_en, clear;

    assign bus.in_ready = (state_q != StDone);
    assign bus.fm_valid = fm_valid_q;
    assign bus.err      = err_q;

    always_comb begin
        accept  = bus.in_valid && bus.in_ready;
        end_cls = bus.in_eoc || bus.in_eof;
        bad     = (bus.in_num == '0) || (bus.in_num > LIT_W'(NUM_LITERALS)) ||
                  (lidx_q == LIT_W'(NUM_LITERALS - 1) && !end_cls) ||
                  (cidx_q == CLS_W'(NUM_CLAUSES - 1) && bus.in_eoc && !bus.in_eof);
        wr_en   = (state_q == StCollect) && accept && !bad;
        // Storage is wiped on an error, on formula hand-off and when a discard ends.
        clear   = ((state_q == StCollect) && accept && bad) ||
                  ((state_q == StDone) && bus.fm_ready) ||
                  ((state_q == StErr) && (err_once_q || (accept && bus.in_eof)));
    end

    always_comb begin
        bus.fm_data = '0;
        for (int c = 0; c < int'(NUM_CLAUSES); c++) begin
            for (int l = 0; l < int'(NUM_LITERALS); l++) begin
                bus.fm_data[FM_W - 1 - c * CLAUSE_W - l * LIT_BITS -: LIT_BITS] = lits_q[c][l];
            end
            bus.fm_data[FM_W - 1 - c * CLAUSE_W - NUM_LITERALS * LIT_BITS -: LIT_W] = clen_q[c];
        end
        bus.fm_data[CLS_W-1:0] = flen_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StCollect;
            lidx_q     <= '0;
            cidx_q     <= '0;
            flen_q     <= '0;
            fm_valid_q <= 1'b0;
            err_q      <= 1'b0;
            err_once_q <= 1'b0;
            for (int c = 0; c < int'(NUM_CLAUSES); c++) begin
                clen_q[c] <= '0;
                for (int l = 0; l < int'(NUM_LITERALS); l++) lits_q[c][l] <= '0;
            end
        end else begin
            if (clear) begin
                lidx_q <= '0;
                cidx_q <= '0;
                flen_q <= '0;
                for (int c = 0; c < int'(NUM_CLAUSES); c++) begin
                    clen_q[c] <= '0;
                    for (int l = 0; l < int'(NUM_LITERALS); l++) lits_q[c][l] <= '0;
                end
            end else if (wr_en) begin
                lits_q[cidx_q][lidx_q] <= {bus.in_num, bus.in_val};
                if (end_cls) begin
                    clen_q[cidx_q] <= lidx_q + 1'b1;
                    lidx_q         <= '0;
                    cidx_q         <= cidx_q + 1'b1;
                end else begin
                    lidx_q <= lidx_q + 1'b1;
                end
                if (bus.in_eof) flen_q <= cidx_q + 1'b1;
            end

            unique case (state_q)
                StCollect: begin
                    if (accept && bad) begin
                        state_q    <= StErr;
                        err_q      <= 1'b1;
                        err_once_q <= bus.in_eof;
                    end else if (accept && bus.in_eof) begin
                        state_q    <= StDone;
                        fm_valid_q <= 1'b1;
                    end
                end
                StDone: begin
                    if (bus.fm_ready) begin
                        state_q    <= StCollect;
                        fm_valid_q <= 1'b0;
                    end
                end
                StErr: begin
                    if (err_once_q || (accept && bus.in_eof)) begin
                        state_q    <= StCollect;
                        err_q      <= 1'b0;
                        err_once_q <= 1'b0;
                    end
                end
                default: state_q <= StCollect;
            endcase
        end
    end
endmodule

// File: doc/formula_loader.md
# formula_loader

Assembles a packed SAT `formula` (`clause_array` plus `len`, laid out exactly as the `common` package defines it) from a serial stream of literal tokens.
- Sits between the host/input interface and the solver core: it writes the structure the solver reads.
- Accepts one literal per cycle over a valid/ready handshake.
- Presents the completed formula on a valid/ready output port.
- Flags malformed streams and discards the rest of them.

## Interface
Parameters:
- NUM_CLAUSES, 5: maximum clauses per formula (matches `number_clauses`).
- NUM_LITERALS, 3: maximum literals per clause; variables are numbered 1..NUM_LITERALS (matches `number_literal`).
- LIT_W, $clog2(NUM_LITERALS+1): width of a literal number and of a clause `len`.
- CLS_W, $clog2(NUM_CLAUSES): width of formula `len`.

Ports:
- clk, input, 1: single clock; all logic on its rising edge.
- rst_n, input, 1: reset, asynchronous and active-low.
- in_valid, input, 1: token present.
- in_ready, output, 1: loader accepts the token this cycle.
- in_num, input, LIT_W: variable number; legal range 1..NUM_LITERALS.
- in_val, input, 1: literal polarity (1 = positive).
- in_eoc, input, 1: token is the last literal of its clause.
- in_eof, input, 1: token is the last literal of the formula; implies end of clause.
- fm_data, output, `formula` width (58 at defaults): packed `formula`. clauses[0] occupies the MSBs and formula `len` the LSBs.
- fm_valid, output, 1: fm_data is complete and stable.
- fm_ready, input, 1: consumer takes the formula.
- err, output, 1: high while the loader is discarding a malformed stream.

## Operation
- State machine has three states: COLLECT, DONE, ERR.
- Counters:
  - lidx (0..NUM_LITERALS-1): next literal slot.
  - cidx (0..NUM_CLAUSES-1): current clause.
- Accept = in_valid && in_ready. in_ready = 1 in COLLECT and ERR, 0 in DONE.
- Valid token accepted in COLLECT:
  - write clauses[cidx].lits[lidx] = {in_num, in_val}.
  - if neither in_eoc nor in_eof: lidx+1.
  - if in_eoc or in_eof: clauses[cidx].len = lidx+1; lidx = 0; cidx+1.
  - if in_eof: formula len = cidx+1 (the cidx value before the increment); go to DONE.
- Error conditions, each checked on an accepted token in COLLECT:
  - in_num == 0 or in_num > NUM_LITERALS.
  - lidx == NUM_LITERALS-1 with in_eoc=0 and in_eof=0 (clause overflow).
  - cidx == NUM_CLAUSES-1 with in_eoc=1 and in_eof=0 (formula overflow).
  - On error: the offending token is not written. Go to ERR.
  - If the offending token carries in_eof, go to ERR for exactly one cycle, then to COLLECT.
- ERR: err=1. Tokens are accepted and dropped. On an accepted in_eof token, clear formula storage and counters, then go to COLLECT.
- DONE: fm_valid=1 and fm_data holds. On fm_ready=1, clear storage to all zeros (the `zero_formula` equivalent) and counters, then go to COLLECT.
- Unused literal slots and clauses stay zero. Every clause written by an accepted token has len >= 1.

## Timing
- Reset (rst_n low, asynchronous):
  - state = COLLECT.
  - fm_data = 0, fm_valid = 0, err = 0, counters = 0.
  - in_ready reads 1 once state is COLLECT.
- Throughput is one token per cycle in COLLECT, with no bubbles between clauses.
- Latency: fm_valid rises on the clock edge that accepts the in_eof token, so it is visible in the next cycle.
- fm_data changes only in COLLECT and on clears. It is stable for the whole time fm_valid is high.
- Output handshake:
  - fm_valid && fm_ready at edge N → fm_valid=0 and in_ready=1 from cycle N+1.
  - fm_valid stays high indefinitely while fm_ready is low; no token is accepted meanwhile.
- err asserts the cycle after the offending token. It deasserts the cycle after the in_eof token that ends the discard.
- rst_n asserted mid-stream, in DONE or in ERR: the partial formula is discarded and all outputs return to their reset values immediately.
- in_num/in_val/in_eoc/in_eof are ignored when in_valid=0. fm_ready is ignored outside DONE.

## Test plan
- Load (x1 ∨ ¬x2) ∧ (x3) with tokens {1,1,eoc0}, {2,0,eoc1}, {3,1,eof1} → fm_valid one cycle after the third accept. fm_data: clause0 = lits{1,1},{2,0},{0,0} len 2; clause1 = lits{3,1} len 1; clauses 2–4 zero; formula len 2.
- Full formula: 5 clauses × 3 literals, every token valid, streamed back to back → no stall. All clause len = 3, formula len = 5, err = 0.
- Backpressure: hold fm_ready=0 for 10 cycles with in_valid=1 → in_ready=0 and fm_data unchanged throughout. Raise fm_ready → fm_data becomes zero next cycle and a new formula loads correctly.
- Errors, each followed by a clean formula that must load correctly:
  - in_num=0 → err next cycle, trailing tokens dropped until eof, then err=0.
  - 4th literal in one clause → same err/discard behaviour.
  - eoc on clause 5 without eof → same err/discard behaviour.
- Reset: assert rst_n low after 2 tokens and again while in DONE → outputs zero immediately. The next stream loads from clause 0, slot 0.
- Single-literal formula {2,1,eof1} → clause0 = {2,1} len 1, formula len 1, fm_valid after 1 cycle.
